// File: rtl/ysyx_25010008_lsu_pkg.sv
// Shared types for the LSU: access sizes, FSM states, AXI response codes.
package ysyx_25010008_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_RD_A,
    ST_RD_D,
    ST_WR,
    ST_WR_B,
    ST_RSP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // Access is unusable: not naturally aligned, or a doubleword on a 32-bit bus.
  function automatic logic bad_access(input logic [2:0] lo, input size_e sz, input int data_w);
    logic bad;
    case (sz)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo[1:0] != 2'b00);
      default: bad = (data_w != 64) || (lo != 3'b000);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_25010008_lsu_align.sv
// Byte-lane steering: store data/strobe shift and load extract + extend.
module ysyx_25010008_lsu_align
  import ysyx_25010008_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] i_off,
  input  size_e                       i_size,
  input  logic                        i_sext,
  input  logic [DATA_W-1:0]           i_wdata,
  input  logic [DATA_W-1:0]           i_rdata,
  output logic [DATA_W-1:0]           o_wdata,
  output logic [DATA_W/8-1:0]         o_wstrb,
  output logic [DATA_W-1:0]           o_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int MSB_W = $clog2(DATA_W);

  logic [NB-1:0]     w_smask;
  logic [MSB_W-1:0]  w_msb;
  logic [DATA_W-1:0] w_sh;
  logic [DATA_W-1:0] w_lmask;

  // Size decode: strobe pattern before shifting and MSB index of the loaded field.
  always_comb begin
    w_smask = '0;
    w_msb   = '0;
    case (i_size)
      SZ_B: begin w_smask = NB'(1);  w_msb = MSB_W'(7);  end
      SZ_H: begin w_smask = NB'(3);  w_msb = MSB_W'(15); end
      SZ_W: begin w_smask = NB'(15); w_msb = MSB_W'(31); end
      default: begin w_smask = {NB{1'b1}}; w_msb = MSB_W'(DATA_W-1); end
    endcase
  end

  assign o_wdata = i_wdata << {i_off, 3'b000};
  assign o_wstrb = w_smask << i_off;

  // Load path: bring the addressed bytes to bit 0, keep the field, fill the rest.
  assign w_sh    = i_rdata >> {i_off, 3'b000};
  assign w_lmask = {DATA_W{1'b1}} >> (MSB_W'(DATA_W-1) - w_msb);
  assign o_rdata = (w_sh & w_lmask) | ((i_sext && w_sh[w_msb]) ? ~w_lmask : '0);

endmodule

// File: rtl/ysyx_25010008_lsu_axi.sv
// Single-outstanding load/store unit bridging EXU requests onto AXI4-Lite.
module ysyx_25010008_lsu_axi
  import ysyx_25010008_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TMO_W  = 8
) (
  input  logic                clock,
  input  logic                reset,
  // EXU request / response
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_sext,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  // AXI4-Lite read
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  // AXI4-Lite write
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int TW    = (TMO_W > 0) ? TMO_W : 1;

  state_e            r_state, w_state_nxt;
  logic              r_wen, r_sext;
  size_e             r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_aw_done, r_w_done;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;
  logic [TW-1:0]     r_tmo;

  logic              w_bad, w_tmo_hit, w_aw_ok, w_w_ok;
  logic [DATA_W-1:0] w_ld_data;

  ysyx_25010008_lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_off   (r_addr[OFF_W-1:0]),
    .i_size  (r_size),
    .i_sext  (r_sext),
    .i_wdata (r_wdata),
    .i_rdata (rdata),
    .o_wdata (wdata),
    .o_wstrb (wstrb),
    .o_rdata (w_ld_data)
  );

  assign w_bad     = bad_access(r_addr[2:0], r_size, DATA_W);
  assign w_tmo_hit = (TMO_W > 0) && (r_tmo == {TW{1'b1}});
  assign w_aw_ok   = r_aw_done || (awvalid && awready);
  assign w_w_ok    = r_w_done  || (wvalid  && wready);

  // Handshake outputs decode straight from state so an async reset clears them at once.
  assign req_ready = (r_state == ST_IDLE);
  assign arvalid   = (r_state == ST_RD_A);
  assign rready    = (r_state == ST_RD_D);
  assign awvalid   = (r_state == ST_WR) && !r_aw_done;
  assign wvalid    = (r_state == ST_WR) && !r_w_done;
  assign bready    = (r_state == ST_WR_B);
  assign rsp_valid = (r_state == ST_RSP);
  assign araddr    = r_addr;
  assign awaddr    = r_addr;
  assign rsp_err   = r_err;
  assign rsp_rdata = r_rdata;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: timeout wins over any beat arriving in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_nxt = ST_CHK;
      ST_CHK:  begin
        if (w_bad)      w_state_nxt = ST_RSP;
        else if (r_wen) w_state_nxt = ST_WR;
        else            w_state_nxt = ST_RD_A;
      end
      ST_RD_A: begin
        if (w_tmo_hit)    w_state_nxt = ST_RSP;
        else if (arready) w_state_nxt = ST_RD_D;
      end
      ST_RD_D: if (w_tmo_hit || rvalid) w_state_nxt = ST_RSP;
      ST_WR: begin
        if (w_tmo_hit)             w_state_nxt = ST_RSP;
        else if (w_aw_ok && w_w_ok) w_state_nxt = ST_WR_B;
      end
      ST_WR_B: if (w_tmo_hit || bvalid) w_state_nxt = ST_RSP;
      ST_RSP:  if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, channel-done flags, timeout counter and response payload.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wen     <= 1'b0;
      r_sext    <= 1'b0;
      r_size    <= SZ_B;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_tmo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_wen   <= req_wen;
          r_sext  <= req_sext;
          r_size  <= size_e'(req_size);
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
        ST_CHK: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_tmo     <= '0;
          if (w_bad) r_err <= 1'b1;
        end
        ST_RD_A, ST_RD_D, ST_WR, ST_WR_B: begin
          r_tmo <= r_tmo + 1'b1;
          if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            if (r_state == ST_RD_D && rvalid) begin
              r_err   <= (rresp != RESP_OKAY);
              r_rdata <= (rresp != RESP_OKAY) ? '0 : w_ld_data;
            end
            if (awvalid && awready) r_aw_done <= 1'b1;
            if (wvalid && wready)   r_w_done  <= 1'b1;
            if (r_state == ST_WR_B && bvalid) r_err <= (bresp != RESP_OKAY);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_lsu_axi.sv
// Directed bench: stimulus pushes expected bus/response items, a monitor checks them.
module tb_ysyx_25010008_lsu_axi;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_sext = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic [31:0] rdata;
  logic [3:0]  wstrb;
  logic [1:0]  rresp, bresp;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;

  always #5 clock = ~clock;

  ysyx_25010008_lsu_axi #(.DATA_W(32), .ADDR_W(32), .TMO_W(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_sext(req_sext),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_chk = 0, n_fail = 0, n_b = 0;

  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t        q_rsp[$];
  logic [31:0] q_ar[$], q_aw[$];
  logic [35:0] q_w[$];

  // Slave behaviour knobs, set by stimulus between transactions.
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0;
  logic [31:0] rd_data = '0;
  logic [1:0]  rd_resp = '0, b_resp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0h expected no transfer", name, act);
  endtask

  // AXI slave model: decisions at negedge, handshakes land at the following posedge.
  bit hs_ar, hs_r, hs_aw, hs_w, hs_b, r_pend, aw_got, w_got, b_pend;
  int ar_cnt, r_cnt, aw_cnt, w_cnt;
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
      end else begin
        if (hs_ar) begin r_pend = 1; r_cnt = 0; end
        if (hs_r)  r_pend = 0;
        if (hs_aw) aw_got = 1;
        if (hs_w)  w_got = 1;
        if (hs_b)  b_pend = 0;
        if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
        if (r_pend && !rready) r_pend = 0;
        if (!awvalid && !wvalid && !bready) begin aw_got = 0; w_got = 0; b_pend = 0; end
        arready = arvalid && (ar_cnt >= ar_dly);
        ar_cnt  = arvalid ? ar_cnt + 1 : 0;
        rvalid  = r_pend && (r_cnt >= r_dly);
        if (r_pend) r_cnt++;
        rdata   = rvalid ? rd_data : 32'h0;
        rresp   = rvalid ? rd_resp : 2'd0;
        awready = awvalid && (aw_cnt >= aw_dly);
        aw_cnt  = awvalid ? aw_cnt + 1 : 0;
        wready  = wvalid && (w_cnt >= w_dly);
        w_cnt   = wvalid ? w_cnt + 1 : 0;
        bvalid  = b_pend;
        bresp   = b_pend ? b_resp : 2'd0;
      end
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_b  = bvalid && bready;
    end
  end

  // Monitor: compare every transfer about to complete against the scoreboard.
  initial begin
    rsp_t        e;
    logic [35:0] ew;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        if (arvalid && arready) begin
          if (q_ar.size() == 0) unexpected("ar", araddr);
          else chk("araddr", araddr, q_ar.pop_front());
        end
        if (awvalid && awready) begin
          if (q_aw.size() == 0) unexpected("aw", awaddr);
          else chk("awaddr", awaddr, q_aw.pop_front());
        end
        if (wvalid && wready) begin
          if (q_w.size() == 0) unexpected("w", {wstrb, wdata});
          else begin
            ew = q_w.pop_front();
            chk("wdata", wdata, ew[31:0]);
            chk("wstrb", wstrb, ew[35:32]);
          end
        end
        if (bvalid && bready) n_b++;
        if (rsp_valid && rsp_ready) begin
          if (q_rsp.size() == 0) unexpected("rsp", {rsp_err, rsp_rdata});
          else begin
            e = q_rsp.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("bus_idle_in_rsp", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
          end
        end
      end
    end
  end

  // Queue expectations and present one request (accepted at the next posedge).
  task automatic send(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] size, input bit sext, input bit bus,
                      input logic [31:0] exp_wd, input logic [3:0] exp_strb,
                      input logic [31:0] exp_rd, input bit exp_err);
    rsp_t e;
    int   t;
    if (bus) begin
      if (wen) begin q_aw.push_back(addr); q_w.push_back({exp_strb, exp_wd}); end
      else q_ar.push_back(addr);
    end
    e.rdata = exp_rd;
    e.err   = exp_err;
    q_rsp.push_back(e);
    @(negedge clock);
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clock); t++; end
    chk("req_ready", req_ready, 1'b1);
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd;
    req_size = size; req_sext = sext;
    @(negedge clock);
    req_valid = 0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;
    req_size = 2'd3; req_sext = ~sext; req_wen = ~wen;
  endtask

  task automatic drain();
    int t = 0;
    while (q_rsp.size() != 0 && t < 600) begin @(negedge clock); t++; end
    if (q_rsp.size() != 0) begin
      unexpected("rsp_timeout", q_rsp.size());
      q_rsp.delete();
    end
  endtask

  initial begin
    int t;
    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_valids", {rsp_valid, arvalid, rready, awvalid, wvalid, bready}, 6'b0);
    chk("rst_rsp", {rsp_err, rsp_rdata}, 33'h0);
    reset = 1;

    // Loads with various sizes, offsets and extension.
    rd_data = 32'hDEAD_BEEF;
    send(0, 32'h8000_0004, 0, 2'd2, 0, 1, 0, 0, 32'hDEAD_BEEF, 0); drain();
    rd_data = 32'h8012_3456;
    send(0, 32'h8000_0003, 0, 2'd0, 1, 1, 0, 0, 32'hFFFF_FF80, 0); drain();
    send(0, 32'h8000_0003, 0, 2'd0, 0, 1, 0, 0, 32'h0000_0080, 0); drain();
    rd_data = 32'h8001_7FFF; ar_dly = 2; r_dly = 3;
    send(0, 32'h8000_0002, 0, 2'd1, 1, 1, 0, 0, 32'hFFFF_8001, 0); drain();
    send(0, 32'h8000_0002, 0, 2'd1, 0, 1, 0, 0, 32'h0000_8001, 0); drain();
    ar_dly = 0; r_dly = 0;

    // Response held under backpressure.
    rd_data = 32'h0000_7F00; rsp_ready = 0;
    send(0, 32'h8000_0011, 0, 2'd0, 1, 1, 0, 0, 32'h0000_007F, 0);
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clock); t++; end
    repeat (3) @(negedge clock);
    chk("rsp_held_valid", rsp_valid, 1'b1);
    chk("rsp_held_rdata", rsp_rdata, 32'h0000_007F);
    rsp_ready = 1; drain();

    // Stores: W ahead of AW by 3 cycles, simultaneous, and AW ahead of W.
    aw_dly = 4; w_dly = 1;
    send(1, 32'h8000_0102, 32'h0000_1234, 2'd1, 0, 1, 32'h1234_0000, 4'b1100, 0, 0); drain();
    aw_dly = 0; w_dly = 0;
    send(1, 32'h8000_0008, 32'hCAFE_F00D, 2'd2, 0, 1, 32'hCAFE_F00D, 4'b1111, 0, 0); drain();
    w_dly = 2;
    send(1, 32'h8000_0201, 32'h1234_56AB, 2'd0, 0, 1, 32'h3456_AB00, 4'b0010, 0, 0); drain();
    w_dly = 0;

    // Illegal accesses never reach the bus.
    send(0, 32'h8000_0002, 0, 2'd2, 0, 0, 0, 0, 0, 1); drain();
    send(1, 32'h8000_0000, 32'h1, 2'd3, 0, 0, 0, 0, 0, 1); drain();
    send(1, 32'h8000_0001, 32'h1, 2'd1, 0, 0, 0, 0, 0, 1); drain();

    // Bus error responses.
    b_resp = 2'd2;
    send(1, 32'h8000_0010, 32'h1111_1111, 2'd2, 0, 1, 32'h1111_1111, 4'b1111, 0, 1); drain();
    b_resp = 2'd0; rd_resp = 2'd3; rd_data = 32'h1234_5678;
    send(0, 32'h8000_0020, 0, 2'd2, 0, 1, 0, 0, 0, 1); drain();
    rd_resp = 2'd0;

    // Read data never arrives: timeout.
    r_dly = 100000;
    send(0, 32'h8000_0030, 0, 2'd2, 0, 1, 0, 0, 0, 1); drain();
    chk("tmo_rready_low", rready, 1'b0);
    r_dly = 0;

    // Async reset while a write address is pending.
    aw_dly = 50; w_dly = 50;
    @(negedge clock);
    req_valid = 1; req_wen = 1; req_addr = 32'h8000_0040; req_wdata = 32'h7777_7777; req_size = 2'd2;
    @(negedge clock);
    req_valid = 0;
    t = 0;
    while (!awvalid && t < 10) begin @(negedge clock); t++; end
    chk("awvalid_pending", awvalid, 1'b1);
    #2 reset = 0;
    #1;
    chk("async_rst_valids", {awvalid, wvalid, rsp_valid}, 3'b0);
    chk("async_rst_req_ready", req_ready, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1; aw_dly = 0; w_dly = 0;
    send(1, 32'h8000_0040, 32'h5A5A_5A5A, 2'd2, 0, 1, 32'h5A5A_5A5A, 4'b1111, 0, 0); drain();

    repeat (3) @(negedge clock);
    chk("b_count", n_b, 5);
    chk("leftover_exp", q_ar.size() + q_aw.size() + q_w.size() + q_rsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
